// File: rtl/param_seq_multiplier_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The slave side is the multiplier; the master side feeds operands and takes results.
interface param_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               iValid_Data;
  logic [WIDTH-1:0]   iData_A;
  logic [WIDTH-1:0]   iData_B;
  logic               iSigned;
  logic               iAck;
  logic               oReady;
  logic               oDone;
  logic [2*WIDTH-1:0] oProduct;

  modport master (
    output iValid_Data, iData_A, iData_B, iSigned, iAck,
    input  oReady, oDone, oProduct
  );

  modport slave (
    input  iValid_Data, iData_A, iData_B, iSigned, iAck,
    output oReady, oDone, oProduct
  );
endinterface

// File: rtl/param_seq_multiplier.sv
// Shift-and-add multiplier, one multiplier bit per cycle, sign handled by
// magnitude multiply plus a final conditional negation.
module param_seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic Clock,
  input  logic Reset,
  param_seq_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam bit ET_ON = (EARLY_TERM != 0);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    acc_sum;
  logic             last;
  logic             sgn_a, sgn_b;

  // Magnitude of the most negative value still fits as WIDTH-bit unsigned.
  assign sgn_a = bus.iSigned & bus.iData_A[WIDTH-1];
  assign sgn_b = bus.iSigned & bus.iData_B[WIDTH-1];
  assign abs_a = sgn_a ? -bus.iData_A : bus.iData_A;
  assign abs_b = sgn_b ? -bus.iData_B : bus.iData_B;

  assign acc_sum = acc_q + (b_q[0] ? a_q : '0);
  assign last = (cnt_q == CW'(WIDTH - 1)) ||
                (ET_ON && (b_q[WIDTH-1:1] == '0));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (bus.iValid_Data) begin
          a_d     = {{WIDTH{1'b0}}, abs_a};
          b_d     = abs_b;
          // A zero multiplier never yields a negated result.
          neg_d   = (sgn_a ^ sgn_b) & (|bus.iData_B);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          prod_d  = neg_q ? -acc_sum : acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.iAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.oReady   = (state_q == IDLE);
  assign bus.oDone    = (state_q == DONE);
  assign bus.oProduct = prod_q;
endmodule

// File: tb/tb_param_seq_multiplier.sv
// Bench for param_seq_multiplier: scoreboarded 32-bit early-term instance,
// plus directed runs on a no-early-term and an 8-bit instance.
module tb_param_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_seq_multiplier_if #(.WIDTH(32)) m ();
  param_seq_multiplier_if #(.WIDTH(32)) z ();
  param_seq_multiplier_if #(.WIDTH(8))  e ();

  param_seq_multiplier #(.WIDTH(32), .EARLY_TERM(1)) u_m (
    .Clock(clk), .Reset(rst), .bus(m.slave)
  );
  param_seq_multiplier #(.WIDTH(32), .EARLY_TERM(0)) u_z (
    .Clock(clk), .Reset(rst), .bus(z.slave)
  );
  param_seq_multiplier #(.WIDTH(8), .EARLY_TERM(1)) u_e (
    .Clock(clk), .Reset(rst), .bus(e.slave)
  );

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rising oDone of the main instance.
  always @(posedge clk) begin
    #1;
    if (m.oDone && !prev_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("product", m.oProduct, x.prod);
        chk("latency", 64'(cyc - x.acc), 64'(x.lat));
      end
    end
    prev_done = m.oDone;
  end

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic s, input logic [63:0] p, input int lat,
                    input int hold, input bit noise, input bit ackv);
    int n;
    n = 0;
    while (!m.oReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_op", 64'(m.oReady), 64'd1);
    m.iValid_Data = 1'b1;
    m.iData_A = a;
    m.iData_B = b;
    m.iSigned = s;
    sb.push_back('{p, lat, cyc + 1});
    @(negedge clk);
    m.iValid_Data = 1'b0;
    chk("busy_after_accept", 64'(m.oReady), 64'd0);
    n = 0;
    while (!m.oDone && n < 100) begin
      if (noise) begin
        m.iValid_Data = n[0];
        m.iData_A = 32'h0000_1234;
        m.iData_B = 32'h0000_0077;
      end
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(m.oDone), 64'd1);
    repeat (hold) begin
      m.iValid_Data = noise;
      @(negedge clk);
      chk("hold_done", 64'(m.oDone), 64'd1);
      chk("hold_prod", m.oProduct, p);
    end
    m.iValid_Data = ackv;
    m.iAck = 1'b1;
    @(negedge clk);
    m.iAck = 1'b0;
    m.iValid_Data = 1'b0;
    chk("idle_after_ack", 64'(m.oReady), 64'd1);
    chk("done_low_after_ack", 64'(m.oDone), 64'd0);
  endtask

  task automatic run_z(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] p, input int lat);
    int n;
    @(negedge clk);
    z.iValid_Data = 1'b1;
    z.iData_A = a;
    z.iData_B = b;
    z.iSigned = s;
    @(posedge clk);
    #1 z.iValid_Data = 1'b0;
    n = 0;
    while (!z.oDone && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("z_product", z.oProduct, p);
    chk("z_latency", 64'(n), 64'(lat));
    @(negedge clk) z.iAck = 1'b1;
    @(negedge clk) z.iAck = 1'b0;
  endtask

  task automatic run_e(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] p, input int lat);
    int n;
    @(negedge clk);
    e.iValid_Data = 1'b1;
    e.iData_A = a;
    e.iData_B = b;
    e.iSigned = s;
    @(posedge clk);
    #1 e.iValid_Data = 1'b0;
    n = 0;
    while (!e.oDone && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("e_product", 64'(e.oProduct), 64'(p));
    chk("e_latency", 64'(n), 64'(lat));
    @(negedge clk) e.iAck = 1'b1;
    @(negedge clk) e.iAck = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    m.iValid_Data = 1'b1;
    m.iData_A = 32'd9;
    m.iData_B = 32'd9;
    m.iSigned = 1'b0;
    m.iAck = 1'b1;
    z.iValid_Data = 1'b0;
    z.iData_A = '0;
    z.iData_B = '0;
    z.iSigned = 1'b0;
    z.iAck = 1'b0;
    e.iValid_Data = 1'b0;
    e.iData_A = '0;
    e.iData_B = '0;
    e.iSigned = 1'b0;
    e.iAck = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(m.oReady), 64'd1);
    chk("reset_done", 64'(m.oDone), 64'd0);
    chk("reset_prod", m.oProduct, 64'd0);
    m.iValid_Data = 1'b0;
    m.iAck = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    op(32'd10, 32'd349525, 1'b0, 64'd3495250, 19, 0, 0, 0);
    op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 3, 0, 0, 0);
    op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'd42, 3, 0, 0, 0);
    op(32'd7, 32'd0, 1'b0, 64'd0, 1, 0, 0, 0);
    op(32'hFFFF_FFFB, 32'd0, 1'b1, 64'd0, 1, 0, 0, 0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 32, 0, 0, 0);
    op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 32, 0, 0, 0);
    op(32'd123, 32'd7, 1'b0, 64'd861, 3, 10, 0, 0);
    op(32'd1000, 32'd1000, 1'b0, 64'd1000000, 10, 3, 1, 0);
    op(32'd3, 32'd4, 1'b1, 64'd12, 3, 0, 0, 1);

    // Abort an operation on its third CALC edge.
    m.iValid_Data = 1'b1;
    m.iData_A = 32'd5;
    m.iData_B = 32'hFFFF_0000;
    m.iSigned = 1'b0;
    @(negedge clk);
    m.iValid_Data = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 64'(m.oReady), 64'd1);
    chk("abort_prod", m.oProduct, 64'd0);
    chk("abort_done", 64'(m.oDone), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (m.oDone) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    op(32'd6, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 3, 0, 0, 0);

    run_z(32'd10, 32'd349525, 1'b0, 64'd3495250, 32);
    run_z(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 32);
    run_e(8'h80, 8'h80, 1'b1, 16'h4000, 8);
    run_e(8'hFF, 8'hFF, 1'b0, 16'hFE01, 8);
    run_e(8'hFD, 8'h05, 1'b1, 16'hFFF1, 3);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; the product is 2*WIDTH bits; legal range 4..64.
REQ-002 Parameter EARLY_TERM, default 1: when 1, the calculation ends as soon as the remaining multiplier bits are all zero.
REQ-003 Clock  input  1  the only clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iValid_Data  input  1  operands on iData_A/iData_B/iSigned are valid this cycle.
REQ-006 iData_A  input  WIDTH  multiplicand.
REQ-007 iData_B  input  WIDTH  multiplier.
REQ-008 iSigned  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-009 iAck  input  1  consumer has taken the result.
REQ-010 oReady  output  1  block is idle and will accept operands.
REQ-011 oDone  output  1  oProduct is valid.
REQ-012 oProduct  output  2*WIDTH  product of the last accepted operation.

Function
REQ-013 The block SHALL implement an FSM with exactly three states: IDLE, CALC and DONE.
REQ-014 The block SHALL drive oReady high only in IDLE and oDone high only in DONE.
REQ-015 Operands SHALL be accepted on an edge where the block is in IDLE and iValid_Data is high.
  - At acceptance the block latches A_reg, B_reg and neg.
  - When iSigned=1: A_reg and B_reg = |operand| (treated as WIDTH-bit unsigned values) and neg = A[msb] XOR B[msb].
  - When iSigned=0: A_reg and B_reg = the raw operands and neg = 0.
  - At acceptance the accumulator is cleared, the bit counter is set to 0 and the FSM goes to CALC.
REQ-016 iValid_Data SHALL be ignored in CALC and in DONE; operands presented there SHALL NOT be latched.
REQ-017 Each CALC cycle SHALL perform the following updates:
  - add A_reg (zero-extended to 2*WIDTH bits) to the accumulator when B_reg[0]=1;
  - shift A_reg left 1 (2*WIDTH-bit register);
  - shift B_reg right 1;
  - increment the counter.
REQ-018 CALC SHALL exit to DONE after the cycle in which either condition holds:
  - counter == WIDTH-1; or
  - EARLY_TERM=1 and (B_reg >> 1) == 0.
REQ-019 Latency: for acceptance at edge t and k CALC cycles, oDone SHALL be high from edge t+k.
  - k = WIDTH when EARLY_TERM=0.
  - k = max(1, index of the highest set bit of B_reg + 1) when EARLY_TERM=1.
REQ-020 On the CALC->DONE transition, oProduct SHALL load the two's-complement negation of the accumulator (2*WIDTH bits) when neg=1, and the accumulator otherwise.
REQ-021 Arithmetic SHALL be exact for all operands, including the signed case -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2); overflow SHALL be impossible.
REQ-022 A zero multiplier SHALL give oProduct=0 with neg forced to 0; -0 SHALL never appear as a nonzero value.
REQ-023 In DONE the block SHALL hold oDone high and oProduct stable until an edge with iAck high, then go to IDLE.
REQ-024 iAck SHALL be ignored in IDLE and in CALC.
REQ-025 iValid_Data and iAck both high in DONE SHALL only return the block to IDLE; the operands SHALL NOT be accepted until the next cycle, in which oReady is high.
REQ-026 oProduct SHALL retain the last result in IDLE and CALC until the next CALC->DONE transition.

Reset
REQ-027 When Reset is high on an edge, the block SHALL go to IDLE from any state on that edge.
REQ-028 On that reset edge the block SHALL clear the accumulator, A_reg, B_reg, counter, neg and oProduct to 0.
REQ-029 After that reset edge, outputs SHALL be oReady=1, oDone=0 and oProduct=0.
REQ-030 Reset SHALL take priority over iValid_Data and iAck on the same edge.
REQ-031 Reset asserted mid-CALC SHALL discard the operation; no oDone pulse SHALL follow.

Verification
REQ-032 WIDTH=32, EARLY_TERM=1, unsigned, A=10, B=349525 -> oProduct=3495250, oDone 19 cycles after acceptance; with EARLY_TERM=0, oDone after 32 cycles and the same product.
REQ-033 WIDTH=32, signed, A=-3, B=5 -> oProduct=64'hFFFFFFFFFFFFFFF1; and A=-7, B=-6 -> oProduct=42.
REQ-034 WIDTH=8, signed, A=8'h80, B=8'h80 -> oProduct=16'h4000; unsigned, A=8'hFF, B=8'hFF -> oProduct=16'hFE01.
REQ-035 B=0 with EARLY_TERM=1 -> one CALC cycle and oProduct=0; A=-5 signed with B=0 -> oProduct=0.
REQ-036 iAck held low for 10 cycles in DONE -> oDone and oProduct stay constant; iValid_Data pulses during CALC and DONE -> ignored, and the result equals the first operation.
REQ-037 Reset asserted on the 3rd CALC cycle -> IDLE next cycle with oReady=1, oProduct=0 and no oDone; a new operation then completes correctly.
